// File: rtl/reg_writeback_queue.sv
// Writeback queue for the 32x32 register file: buffers {addr,data} results and drains one per cycle
// to a registered write port (push at E0 -> wr_en at E1); in_ready drops when full. Bypass: WBQ_BYPASS_EN.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      flush,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      byp_hit1,
  output logic [DATA_W-1:0]         byp_data1,
  output logic                      byp_hit2,
  output logic [DATA_W-1:0]         byp_data2,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               push_vld;
  logic               drain_vld;

  assign in_ready = rst_n && (count_q < CNT_W'(DEPTH));

  // Writes to r0 complete the handshake but are dropped; flush discards a same-edge push/drain.
  assign push_vld  = in_valid && in_ready && (in_addr != '0) && !flush;
  assign drain_vld = (count_q != '0) && !wr_stall && !flush;

  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_vld) begin
        mem_d[tail_q] = '{addr: in_addr, data: in_data};
        tail_d        = tail_q + 1'b1;
      end
      if (drain_vld) begin
        wr_en_d   = 1'b1;
        wr_addr_d = mem_q[head_q].addr;
        wr_data_d = mem_q[head_q].data;
        head_d    = head_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push_vld) - CNT_W'(drain_vld);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;

`ifdef WBQ_BYPASS_EN
  logic [ADDR_W-1:0] rd_addr_c [2];
  logic              byp_hit_c [2];
  logic [DATA_W-1:0] byp_data_c [2];
  logic [PTR_W-1:0]  idx_c [DEPTH];

  assign rd_addr_c[0] = rd_addr1;
  assign rd_addr_c[1] = rd_addr2;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      idx_c[i] = head_q + PTR_W'(i);
    end
  end

  // Oldest-to-newest scan so the newest queued match wins; the in-flight write is the fallback.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      byp_hit_c[p]  = 1'b0;
      byp_data_c[p] = '0;
      if (wr_en_q && (wr_addr_q == rd_addr_c[p])) begin
        byp_hit_c[p]  = 1'b1;
        byp_data_c[p] = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < count_q) && (mem_q[idx_c[i]].addr == rd_addr_c[p])) begin
          byp_hit_c[p]  = 1'b1;
          byp_data_c[p] = mem_q[idx_c[i]].data;
        end
      end
      if (rd_addr_c[p] == '0) begin
        byp_hit_c[p]  = 1'b0;
        byp_data_c[p] = '0;
      end
    end
  end

  assign byp_hit1  = byp_hit_c[0];
  assign byp_data1 = byp_data_c[0];
  assign byp_hit2  = byp_hit_c[1];
  assign byp_data2 = byp_data_c[1];
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign byp_hit1  = 1'b0;
  assign byp_data1 = '0;
  assign byp_hit2  = 1'b0;
  assign byp_data2 = '0;
`endif

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Writer side of the 32x32 register file: buffers completed results (destination address + data) from execute/load units and drains them into the register file's single write port, one per cycle.
- Drives the register file's write-enable, write-address and write-data inputs from registered outputs.
- Optionally reports pending, not-yet-written values for operand bypass on the two read addresses.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer has a result.
- in_ready  output  1  queue can accept; equals (count < DEPTH) and rst_n.
- in_addr  input  ADDR_W  destination register.
- in_data  input  DATA_W  result value.
- flush  input  1  synchronous discard of all queued entries.
- wr_stall  input  1  register file cannot take a write this cycle.
- wr_en  output  1  register file write enable (registered).
- wr_addr  output  ADDR_W  register file write address (registered).
- wr_data  output  DATA_W  register file write data (registered).
- rd_addr1  input  ADDR_W  operand read address 1.
- rd_addr2  input  ADDR_W  operand read address 2.
- byp_hit1  output  1  pending value exists for rd_addr1.
- byp_data1  output  DATA_W  newest pending value for rd_addr1.
- byp_hit2  output  1  pending value exists for rd_addr2.
- byp_data2  output  DATA_W  newest pending value for rd_addr2.
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n=0 at an edge):
  - head, tail and count cleared to 0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - in_ready=0 while rst_n is low.
  - Any entry mid-queue is lost.
- Push: in_valid && in_ready sampled at an edge writes {in_addr, in_data} at tail; tail wraps modulo DEPTH; count increments.
- Address 0 (hardwired zero register):
  - in_valid with in_addr==0 completes the handshake but is not enqueued.
  - count and tail are unchanged.
- Drain, evaluated at each edge using the pre-edge count:
  - If count>0 and !wr_stall: wr_en<=1, wr_addr/wr_data<=head entry; head wraps; count decrements.
  - Otherwise wr_en<=0; wr_addr/wr_data hold their last value.
- Latency: a result pushed at edge E0 drives wr_en=1 after edge E1 (if unstalled). The register file commits it at E2.
- Simultaneous push and drain in one edge: both occur; count is unchanged. A full queue still rejects in the cycle it drains (in_ready reflects the pre-edge count; no pass-through).
- Full: in_ready=0; in_valid is ignored and the producer must hold.
- Empty: wr_en=0 next cycle; wr_stall has no effect.
- flush:
  - Empties the queue (head=tail=0, count=0) and sets wr_en<=0.
  - A push or drain in the same edge is discarded.
  - A write already presented on wr_* before the edge is not recalled.
- Ordering: strict FIFO. Two entries to the same address are both written, oldest first, so the last value wins.
- rst_n has priority over flush; flush has priority over push and drain.

Optional Feature:
- Macro WBQ_BYPASS_EN.
- Defined:
  - byp_hitN/byp_dataN are combinational.
  - Search priority: newest queued entry matching rd_addrN (tail-1 backward to head); then the entry currently on wr_* if wr_en=1; otherwise miss.
  - rd_addrN==0 never hits.
  - Entries removed by flush never hit.
- Undefined: byp_hit1/2 and byp_data1/2 are tied to 0 and no search logic is built.

Test Plan:
- Reset with 3 entries queued -> count=0, wr_en=0, wr_addr=0, wr_data=0 after the edge; in_ready=1 once rst_n=1.
- Push {3, 0x3BE2} on an idle queue, no stall -> wr_en=1, wr_addr=3, wr_data=0x3BE2 after the second edge, for exactly one cycle.
- wr_stall=1, then push 5 entries with DEPTH=4 -> in_ready=0 after the 4th push, 5th held; release stall -> 4 writes on consecutive cycles in push order, then the 5th.
- Push {0, 0xFFFF} -> handshake completes, count stays 0, no wr_en pulse.
- With WBQ_BYPASS_EN, stall and push {7, 0x1111} then {7, 0x2222}; rd_addr1=7 -> byp_hit1=1, byp_data1=0x2222. rd_addr2=8 -> byp_hit2=0.
- Queue holds 2 entries, assert flush with a simultaneous push -> count=0, wr_en=0 next cycle, no further writes.
